// File: rtl/frame_tick_gen.sv
// ---------------------------------------------------------------------------
// frame_tick_gen: divides clk into one-cycle frame ticks and owns game level
// and derived speed_count. Optional macro FRAME_STATS_EN adds frame_total.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module frame_tick_gen #(
  parameter int DIV         = 833333,
  parameter int DIV_W       = 20,
  parameter int MAX_LEVEL   = 15,
  parameter int START_SPEED = 30,
  parameter int SPEED_STEP  = 2,
  parameter int MIN_SPEED   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic        pause,
  input  logic        level_up,
  input  logic        restart,
  output logic        frame_tick,
  output logic [10:0] speed_count,
  output logic [3:0]  level
`ifdef FRAME_STATS_EN
  ,
  output logic [15:0] frame_total
`endif
);

  localparam logic [DIV_W-1:0] c_div_last    = DIV_W'(DIV - 1);
  localparam logic [3:0]       c_max_level   = 4'(MAX_LEVEL);
  localparam logic [10:0]      c_start_speed = 11'(START_SPEED);
  localparam logic [10:0]      c_min_speed   = 11'(MIN_SPEED);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_q, div_d;
  logic               tick_q, tick_d;
  logic [3:0]         level_q, level_d;
  logic [10:0]        speed_q, speed_d;
  logic               w_count_en;
  logic               w_wrap;
  logic signed [31:0] w_speed_raw;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (run) state_d = ST_RUN;
      ST_RUN: begin
        if (!run)       state_d = ST_IDLE;
        else if (pause) state_d = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (!run)        state_d = ST_IDLE;
        else if (!pause) state_d = ST_RUN;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  // Count only while staying in RUN, so the transition cycle into RUN and a
  // falling run on the wrap cycle never advance the divider or tick.
  assign w_count_en = (state_q == ST_RUN) && run && !pause;
  assign w_wrap     = w_count_en && (div_q == c_div_last);

  always_comb begin
    div_d = div_q;
    if (restart || (state_d == ST_IDLE)) begin
      div_d = '0;
    end else if (w_wrap) begin
      div_d = '0;
    end else if (w_count_en) begin
      div_d = div_q + DIV_W'(1);
    end
  end

  assign tick_d = w_wrap && !restart;

  always_comb begin
    level_d = level_q;
    if (restart) begin
      level_d = '0;
    end else if (level_up && (level_q != c_max_level)) begin
      level_d = level_q + 4'd1;
    end
  end

  // Speed follows the registered level, giving one cycle of latency.
  assign w_speed_raw = START_SPEED - ($signed(32'(level_q)) * SPEED_STEP);

  always_comb begin
    speed_d = speed_q;
    if (restart) begin
      speed_d = c_start_speed;
    end else if (w_speed_raw < MIN_SPEED) begin
      speed_d = c_min_speed;
    end else begin
      speed_d = 11'(w_speed_raw);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      tick_q  <= 1'b0;
      level_q <= '0;
      speed_q <= c_start_speed;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      tick_q  <= tick_d;
      level_q <= level_d;
      speed_q <= speed_d;
    end
  end

  assign frame_tick  = tick_q;
  assign speed_count = speed_q;
  assign level       = level_q;

`ifdef FRAME_STATS_EN
  logic [15:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (restart) begin
      total_d = '0;
    end else if (tick_d) begin
      total_d = total_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      total_q <= '0;
    end else begin
      total_q <= total_d;
    end
  end

  assign frame_total = total_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_tick_gen.sv
// ---------------------------------------------------------------------------
// tb_frame_tick_gen: table-driven self-checking bench for frame_tick_gen.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_frame_tick_gen;

  localparam int DIV = 4;

  logic        clk = 1'b0;
  logic        reset, run, pause, level_up, restart;
  logic        frame_tick;
  logic [10:0] speed_count;
  logic [3:0]  level;
`ifdef FRAME_STATS_EN
  logic [15:0] frame_total;
`endif

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic run, pause, lu, rs;
    logic tick;
    int   lvl;
    int   spd;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];

  frame_tick_gen #(
    .DIV(DIV), .DIV_W(3), .MAX_LEVEL(15),
    .START_SPEED(30), .SPEED_STEP(2), .MIN_SPEED(2)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .pause(pause),
    .level_up(level_up), .restart(restart),
    .frame_tick(frame_tick), .speed_count(speed_count), .level(level)
`ifdef FRAME_STATS_EN
    , .frame_total(frame_total)
`endif
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic p, input logic u,
                              input logic s, input logic t, input int l, input int sp);
    vec_t v;
    v.run = r; v.pause = p; v.lu = u; v.rs = s;
    v.tick = t; v.lvl = l; v.spd = sp;
    return v;
  endfunction

  function automatic int exp_spd(input int l);
    int v;
    v = 30 - 2 * l;
    return (v < 2) ? 2 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic step(input vec_t v, input string tag, input int idx);
    vec_t e;
    run = v.run; pause = v.pause; level_up = v.lu; restart = v.rs;
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk($sformatf("%s[%0d] tick", tag, idx), 32'(frame_tick), 32'(e.tick));
    chk($sformatf("%s[%0d] level", tag, idx), 32'(level), e.lvl);
    chk($sformatf("%s[%0d] speed", tag, idx), 32'(speed_count), e.spd);
  endtask

  initial begin
    // Steady RUN, level_up on a tick, pause/resume phase, run falling on wrap,
    // restart in IDLE, restart on a wrap cycle.
    vecs.push_back(mk(1,0,0,0, 0, 0, 30));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0, 0, 0, 30));
    vecs.push_back(mk(1,0,0,0, 1, 0, 30));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0, 0, 0, 30));
    vecs.push_back(mk(1,0,1,0, 1, 1, 30));
    vecs.push_back(mk(1,0,0,0, 0, 1, 28));
    vecs.push_back(mk(1,0,0,0, 0, 1, 28));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(1,1,0,0, 0, 1, 28));
    vecs.push_back(mk(1,0,0,0, 0, 1, 28));
    vecs.push_back(mk(1,0,0,0, 0, 1, 28));
    vecs.push_back(mk(1,0,0,0, 1, 1, 28));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0, 0, 1, 28));
    vecs.push_back(mk(0,0,0,0, 0, 1, 28));
    vecs.push_back(mk(0,0,1,0, 0, 2, 28));
    vecs.push_back(mk(0,0,0,0, 0, 2, 26));
    vecs.push_back(mk(0,0,1,1, 0, 0, 30));
    vecs.push_back(mk(0,0,0,0, 0, 0, 30));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(1,0,0,0, 0, 0, 30));
    vecs.push_back(mk(1,0,0,1, 0, 0, 30));
    for (int i = 0; i < 3; i++) vecs.push_back(mk(1,0,0,0, 0, 0, 30));
    vecs.push_back(mk(1,0,0,0, 1, 0, 30));

    reset = 1'b1; run = 1'b0; pause = 1'b0; level_up = 1'b0; restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset tick", 32'(frame_tick), 0);
    chk("reset level", 32'(level), 0);
    chk("reset speed", 32'(speed_count), 30);
`ifdef FRAME_STATS_EN
    chk("reset total", 32'(frame_total), 0);
`endif
    reset = 1'b0;

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], "vec", i);

    // Level saturation and speed clamp, from IDLE.
    step(mk(0,0,0,0, 0, 0, 30), "sat", 0);
    for (int i = 1; i <= 20; i++) begin
      int l, lp;
      l  = (i > 15) ? 15 : i;
      lp = (i - 1 > 15) ? 15 : i - 1;
      step(mk(0,0,1,0, 0, l, exp_spd(lp)), "sat_up", i);
      step(mk(0,0,0,0, 0, l, exp_spd(l)), "sat_hold", i);
    end

    // restart together with level_up at level 5 while running.
    step(mk(0,0,0,1, 0, 0, 30), "rst", 0);
    for (int i = 1; i <= 5; i++) step(mk(0,0,1,0, 0, i, exp_spd(i - 1)), "rst_up", i);
    step(mk(0,0,0,0, 0, 5, 20), "rst", 1);
    for (int i = 0; i < 3; i++) step(mk(1,0,0,0, 0, 5, 20), "rst_run", i);
    step(mk(1,0,1,1, 0, 0, 30), "rst", 2);
    for (int i = 0; i < 3; i++) step(mk(1,0,0,0, 0, 0, 30), "rst_after", i);
    step(mk(1,0,0,0, 1, 0, 30), "rst", 3);

    // Asynchronous reset with divider at 3 and level nonzero.
    step(mk(1,0,1,0, 0, 1, 30), "ares", 0);
    step(mk(1,0,0,0, 0, 1, 28), "ares", 1);
    step(mk(1,0,0,0, 0, 1, 28), "ares", 2);
    #2 reset = 1'b1;
    #1;
    chk("ares level", 32'(level), 0);
    chk("ares speed", 32'(speed_count), 30);
    chk("ares tick", 32'(frame_tick), 0);
`ifdef FRAME_STATS_EN
    chk("ares total", 32'(frame_total), 0);
`endif
    @(posedge clk);
    #1;
    chk("ares held tick", 32'(frame_tick), 0);
    reset = 1'b0;
    for (int k = 1; k <= 13; k++) begin
      logic t;
      t = (k >= 5) && ((k % DIV) == 1);
      step(mk(1,0,0,0, t, 0, 30), "post", k);
    end
`ifdef FRAME_STATS_EN
    chk("post total", 32'(frame_total), 3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/frame_tick_gen.md
Name: frame_tick_gen

Overview:
Upstream pacing stage for the frame counter. Divides the system clock into one-cycle frame ticks (default 60 Hz from 50 MHz), which drive the frame counter's enable input. It also owns the game level and derives the speed_count value that the frame counter compares against. The game control FSM drives it with run, pause, level_up and restart.

Parameters:
DIV, 833333, clock cycles per frame tick; must be >= 2.
DIV_W, 20, width of the divider counter; must satisfy 2^DIV_W >= DIV.
MAX_LEVEL, 15, saturation value of level.
START_SPEED, 30, speed_count at level 0.
SPEED_STEP, 2, speed_count decrement per level.
MIN_SPEED, 2, lower clamp on speed_count.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
run  in  1  level-sensitive game-active enable.
pause  in  1  level-sensitive hold; meaningful only while run=1.
level_up  in  1  one-cycle pulse: advance one level.
restart  in  1  synchronous clear of level and divider.
frame_tick  out  1  one-cycle pulse once per DIV cycles in RUN.
speed_count  out  11  frames per move; feeds the frame counter.
level  out  4  current level, 0..MAX_LEVEL.

Behaviour:
- Reset values:
  - state=IDLE, divider=0, frame_tick=0, level=0.
  - speed_count=START_SPEED, zero-extended to 11 bits.
- States and transitions:
  - IDLE -> RUN when run=1.
  - RUN -> PAUSE when run=1 and pause=1.
  - PAUSE -> RUN when pause=0 and run=1.
  - RUN or PAUSE -> IDLE when run=0; run=0 overrides pause.
- Divider:
  - IDLE: divider forced to 0; no tick.
  - PAUSE: divider holds its value; no tick.
  - RUN: increments each cycle. When divider==DIV-1 it wraps to 0 and frame_tick=1 on the following cycle (registered output, 1-cycle latency).
  - Resuming from PAUSE continues from the held value, so no phase is lost.
  - Steady RUN produces ticks exactly DIV cycles apart; first tick is DIV cycles after entering RUN from IDLE.
- Level:
  - level_up increments level, saturating at MAX_LEVEL.
  - level_up is accepted in any state, including IDLE.
- Speed:
  - speed_count = max(START_SPEED - level*SPEED_STEP, MIN_SPEED).
  - Computed in signed arithmetic wide enough that the subtraction never wraps.
  - Registered: updates one cycle after level changes.
- restart (synchronous):
  - Clears level to 0, speed_count to START_SPEED, divider to 0, and suppresses that cycle's tick.
  - State is unchanged.
  - Has priority over level_up in the same cycle.
- Simultaneous events:
  - level_up on a tick cycle: both take effect; the tick is not delayed.
  - run falling on the wrap cycle: no tick is issued.
- Asynchronous reset mid-operation: all outputs return to reset values immediately; no partial tick is produced.

Optional Feature:
Macro FRAME_STATS_EN.
- Defined: adds output frame_total [15:0], reset to 0, incremented on every frame_tick and wrapping at 65535->0; cleared by restart.
- Not defined: port and logic absent; all other behaviour is identical.

Test Plan:
- DIV=4, reset then run=1 held -> frame_tick pulses 1 cycle wide, first 4 cycles after run rises, then every 4 cycles; level=0, speed_count=30.
- DIV=4, run=1, pause=1 for 10 cycles starting with divider=2 -> no tick during pause; first tick 2 cycles after pause falls (divider resumes at 2).
- 20 level_up pulses -> level saturates at 15; speed_count steps 28, 26, ..., 4, then clamps at 2 from level 14 onward; each value appears 1 cycle after its level change.
- level=5 (speed_count=20), assert restart and level_up together -> next cycle level=0, speed_count=30, divider=0, no tick that cycle.
- DIV=4, level_up on the same cycle as a tick -> tick still asserted; level increments by 1.
- Async reset asserted mid-divide (divider=3) -> frame_tick=0 and level=0 immediately; with FRAME_STATS_EN, frame_total=0; 3 ticks after release -> frame_total=3.
